// File: rtl/ps2_key_decoder_if.sv
// PS/2 line and decoded-key output bundle between the keyboard side and the decoder.
// The decoder connects through the slave modport; the keyboard/bench side uses master.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [3:0] ps2_data;
  logic       ps2_en;
  logic       frame_err;

  modport slave (
    input  ps2_clk,
    input  ps2_dat,
    output ps2_data,
    output ps2_en,
    output frame_err
  );

  modport master (
    output ps2_clk,
    output ps2_dat,
    input  ps2_data,
    input  ps2_en,
    input  frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver plus make/break decoder that turns nine keys into 4-bit sound codes.
// The frame receiver feeds a one-byte pipeline stage into the scancode decoder.
module ps2_key_decoder #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input logic              clock,
  input logic              reset,
  ps2_key_decoder_if.slave ps2_bus_io
);

  typedef enum logic [1:0] {RxIdle, RxData, RxParity, RxStop} rx_state_e;
  typedef enum logic [1:0] {DecMake, DecBreak, DecExt} dec_state_e;

  logic        clk_meta_q, clk_sync_q, clk_prev_q;
  logic        dat_meta_q, dat_sync_q;
  logic        fall;
  logic        timeout;

  rx_state_e   rx_state_q, rx_state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        parity_q, parity_d;
  logic [15:0] wdog_q, wdog_d;
  logic        byte_vld_q, byte_vld_d;
  logic [7:0]  byte_q, byte_d;
  logic        frame_err_q, frame_err_d;

  dec_state_e  dec_state_q, dec_state_d;
  logic [3:0]  held_key_q, held_key_d;
  logic [3:0]  ps2_data_q, ps2_data_d;
  logic        ps2_en_q, ps2_en_d;
  logic [3:0]  key_code;

  // Synchronizers idle high, matching an idle PS/2 line, so reset never fakes an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_bus_io.ps2_clk;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_bus_io.ps2_dat;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign fall    = ~clk_sync_q & clk_prev_q;
  assign timeout = (rx_state_q != RxIdle) && !fall && (wdog_q == TIMEOUT - 16'd1);

  always_comb begin
    rx_state_d  = rx_state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    parity_d    = parity_q;
    byte_vld_d  = 1'b0;
    byte_d      = byte_q;
    frame_err_d = 1'b0;
    wdog_d      = wdog_q;

    if (fall) begin
      wdog_d = '0;
    end else if (rx_state_q != RxIdle) begin
      wdog_d = wdog_q + 16'd1;
    end

    if (timeout) begin
      rx_state_d  = RxIdle;
      frame_err_d = 1'b1;
    end else if (fall) begin
      unique case (rx_state_q)
        RxIdle: begin
          if (!dat_sync_q) begin
            rx_state_d = RxData;
            bit_cnt_d  = '0;
            shift_d    = '0;
          end
        end
        RxData: begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_state_d = RxParity;
          end
        end
        RxParity: begin
          parity_d   = dat_sync_q;
          rx_state_d = RxStop;
        end
        RxStop: begin
          rx_state_d = RxIdle;
          // Odd parity over data+parity, and a high stop bit.
          if ((^shift_q ^ parity_q) && dat_sync_q) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: rx_state_d = RxIdle;
      endcase
    end
  end

  always_comb begin
    case (byte_q)
      8'h1C:   key_code = 4'd1;
      8'h1B:   key_code = 4'd2;
      8'h23:   key_code = 4'd3;
      8'h2B:   key_code = 4'd4;
      8'h34:   key_code = 4'd5;
      8'h33:   key_code = 4'd6;
      8'h3B:   key_code = 4'd7;
      8'h42:   key_code = 4'd8;
      8'h4B:   key_code = 4'd9;
      default: key_code = 4'd0;
    endcase
  end

  always_comb begin
    dec_state_d = dec_state_q;
    held_key_d  = held_key_q;
    ps2_data_d  = ps2_data_q;
    ps2_en_d    = 1'b0;

    if (byte_vld_q) begin
      unique case (dec_state_q)
        DecMake: begin
          if (byte_q == 8'hF0) begin
            dec_state_d = DecBreak;
          end else if (byte_q == 8'hE0) begin
            dec_state_d = DecExt;
          end else if (key_code != 4'd0 && key_code != held_key_q) begin
            held_key_d = key_code;
            ps2_data_d = key_code;
            ps2_en_d   = 1'b1;
          end
        end
        DecBreak: begin
          dec_state_d = DecMake;
          if (key_code != 4'd0 && key_code == held_key_q) begin
            held_key_d = 4'd0;
            ps2_data_d = 4'd0;
            ps2_en_d   = 1'b1;
          end
        end
        // Extended keys are swallowed; E0 F0 still routes through the break state.
        DecExt: dec_state_d = (byte_q == 8'hF0) ? DecBreak : DecMake;
        default: dec_state_d = DecMake;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q  <= RxIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      parity_q    <= 1'b0;
      wdog_q      <= '0;
      byte_vld_q  <= 1'b0;
      byte_q      <= '0;
      frame_err_q <= 1'b0;
      dec_state_q <= DecMake;
      held_key_q  <= '0;
      ps2_data_q  <= '0;
      ps2_en_q    <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      parity_q    <= parity_d;
      wdog_q      <= wdog_d;
      byte_vld_q  <= byte_vld_d;
      byte_q      <= byte_d;
      frame_err_q <= frame_err_d;
      dec_state_q <= dec_state_d;
      held_key_q  <= held_key_d;
      ps2_data_q  <= ps2_data_d;
      ps2_en_q    <= ps2_en_d;
    end
  end

  assign ps2_bus_io.ps2_data  = ps2_data_q;
  assign ps2_bus_io.ps2_en    = ps2_en_q;
  assign ps2_bus_io.frame_err = frame_err_q;

endmodule
